crossing_scheduler: RTL and testbench

Arbitrates two pedestrian crosswalk push-buttons (A, B) for the single intersection's light sequencer. It debounces and latches button presses and enforces a minimum vehicle-green interval. It grants crossing phases round-robin over a req/ack/done handshake and drives per-crosswalk "wait" lamps. It sits between the board buttons and the light sequencer, which runs the actual lamp phases.

---
 rtl/crossing_scheduler.sv | 157 +++++++++++++++
 tb/tb_crossing_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/crossing_scheduler.sv
// Pedestrian crossing scheduler: debounces buttons A/B, latches requests, and
// grants crossings round-robin after a minimum vehicle-green interval.
// Optional CROSS_TIMEOUT_EN adds a crossing watchdog with a sticky fault output.
module crossing_scheduler #(
  parameter int unsigned TIMER_SCALE    = 16000000,
  parameter int unsigned MIN_GREEN_S    = 10,
  parameter int unsigned DEBOUNCE_TICKS = 160000,
  parameter int unsigned TIMEOUT_S      = 30
) (
  input  logic pin3_clk_16mhz,
  input  logic pin2_rst_n,
  input  logic pin9_btn_a,
  input  logic pin10_btn_b,
  input  logic cross_ack,
  input  logic cross_done,
  output logic cross_req,
  output logic cross_sel,
  output logic pin11_wait_a,
  output logic pin12_wait_b,
  output logic pin13_fault
);

  localparam int unsigned TW = 30;
  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] MIN_GREEN_TICKS = TW'(MIN_GREEN_S * TIMER_SCALE);
  localparam logic [DW-1:0] DEB_LAST        = DW'(DEBOUNCE_TICKS - 1);

  // Both timer reload values must fit the 30-bit main timer.
  if ((64'(MIN_GREEN_S) * 64'(TIMER_SCALE) >= (64'd1 << TW)) ||
      (64'(TIMEOUT_S) * 64'(TIMER_SCALE) >= (64'd1 << TW))) begin : g_cfg_check
    $error("crossing_scheduler: timer reload exceeds 30 bits");
  end

  typedef enum logic [1:0] {
    VEH_GREEN = 2'd0,
    GRANT     = 2'd1,
    CROSSING  = 2'd2
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            rr;
  logic [1:0]      pend;
  logic [1:0]      raw_c;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      acc;
  logic [1:0]      acc_q;
  logic [DW-1:0]   deb_cnt [2];
  logic [1:0]      rise_c;
  logic [1:0]      sel_mask_c;
  logic [1:0]      set_c;
  logic [1:0]      clr_c;
  logic            timeout_c;
  logic            end_c;

  assign raw_c = {pin10_btn_b, pin9_btn_a};

  // Per-button synchronizer and debounce; accepted level moves only after a stable run.
  always_ff @(posedge pin3_clk_16mhz or negedge pin2_rst_n) begin
    if (!pin2_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      acc_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      acc_q <= acc;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          acc[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef CROSS_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_TICKS = TW'(TIMEOUT_S * TIMER_SCALE);
  logic fault_q;
  assign pin13_fault = fault_q;
  assign timeout_c   = (timer == TW'(1));
`else
  assign pin13_fault = 1'b0;
  assign timeout_c   = 1'b0;
`endif

  // Pending-flag update: the served crosswalk ignores presses, and a clear beats a set.
  always_comb begin
    rise_c     = acc & ~acc_q;
    sel_mask_c = cross_sel ? 2'b10 : 2'b01;
    set_c      = rise_c;
    clr_c      = 2'b00;
    end_c      = (state == CROSSING) && (cross_done || timeout_c);
    if (state != VEH_GREEN) set_c = rise_c & ~sel_mask_c;
    if (end_c) clr_c = sel_mask_c;
  end

  always_ff @(posedge pin3_clk_16mhz or negedge pin2_rst_n) begin
    if (!pin2_rst_n) begin
      state     <= VEH_GREEN;
      timer     <= MIN_GREEN_TICKS;
      rr        <= 1'b0;
      pend      <= '0;
      cross_req <= 1'b0;
      cross_sel <= 1'b0;
`ifdef CROSS_TIMEOUT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      pend <= (pend | set_c) & ~clr_c;
      if (timer != '0) timer <= timer - TW'(1);
      case (state)
        VEH_GREEN: begin
          if ((timer == '0) && (pend != 2'b00)) begin
            cross_sel <= (pend == 2'b11) ? rr : pend[1];
            cross_req <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (cross_ack) begin
            cross_req <= 1'b0;
            state     <= CROSSING;
`ifdef CROSS_TIMEOUT_EN
            timer     <= TIMEOUT_TICKS;
`endif
          end
        end
        CROSSING: begin
          if (end_c) begin
            rr    <= ~cross_sel;
            timer <= MIN_GREEN_TICKS;
            state <= VEH_GREEN;
`ifdef CROSS_TIMEOUT_EN
            if (!cross_done) fault_q <= 1'b1;
`endif
          end
        end
        default: begin
          state     <= VEH_GREEN;
          cross_req <= 1'b0;
        end
      endcase
    end
  end

  assign pin11_wait_a = pend[0];
  assign pin12_wait_b = pend[1];

endmodule

// File: tb/tb_crossing_scheduler.sv
// Scoreboard bench for crossing_scheduler with a scaled-down timer configuration.
module tb_crossing_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_a, btn_b, ack, done;
  logic req, sel, wait_a, wait_b, fault;

  int n_vec = 0;
  int n_err = 0;
  logic exp_q [$];

  crossing_scheduler #(
    .TIMER_SCALE(10),
    .MIN_GREEN_S(2),
    .DEBOUNCE_TICKS(4),
    .TIMEOUT_S(3)
  ) dut (
    .pin3_clk_16mhz(clk),
    .pin2_rst_n(rst_n),
    .pin9_btn_a(btn_a),
    .pin10_btn_b(btn_b),
    .cross_ack(ack),
    .cross_done(done),
    .cross_req(req),
    .cross_sel(sel),
    .pin11_wait_a(wait_a),
    .pin12_wait_b(wait_b),
    .pin13_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic a, input logic b, input int cycles);
    btn_a = a;
    btn_b = b;
    repeat (cycles) tick();
    btn_a = 1'b0;
    btn_b = 1'b0;
  endtask

  // Waits for cross_req, then pops and compares the expected crosswalk.
  task automatic wait_grant(input string tag, input bit stray, output int cyc);
    int n;
    logic e;
    n = 0;
    while (req !== 1'b1 && n < 200) begin
      if (stray && n == 5) begin
        ack  = 1'b1;
        done = 1'b1;
      end
      tick();
      ack  = 1'b0;
      done = 1'b0;
      n++;
    end
    cyc = n;
    check({tag, "_req"}, 32'(req), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
    check({tag, "_sel"}, 32'(sel), 32'(e));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    int cyc;
    int bad;
    logic sel0;
    rst_n = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;
    ack   = 1'b0;
    done  = 1'b0;
    repeat (2) tick();
    check("rst_req", 32'(req), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_wait", 32'({wait_a, wait_b}), 0);
    check("rst_fault", 32'(fault), 0);
    rst_n = 1'b1;

    // Idle: no presses, nothing requested.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (req !== 1'b0 || wait_a !== 1'b0 || wait_b !== 1'b0 || fault !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 0);

    // Glitch shorter than debounce.
    press(1'b1, 1'b0, 3);
    repeat (10) tick();
    check("short_pulse", 32'(wait_a), 0);

    // Held press: lamp exactly 7 cycles after first sample.
    btn_a = 1'b1;
    repeat (6) tick();
    check("lat_a_early", 32'(wait_a), 0);
    tick();
    check("lat_a", 32'(wait_a), 1);
    exp_q.push_back(1'b0);
    wait_grant("grant_a", 1'b0, cyc);
    repeat (2) tick();
    btn_a = 1'b0;

    // Ack withheld: request stable, stray done ignored.
    bad = 0;
    sel0 = sel;
    for (int i = 0; i < 50; i++) begin
      done = (i == 10 || i == 30);
      tick();
      done = 1'b0;
      if (req !== 1'b1 || sel !== sel0) bad++;
    end
    check("grant_hold", 32'(bad), 0);
    check("grant_wait_a", 32'(wait_a), 1);
    do_ack();
    check("ack_drop", 32'(req), 0);

    // During crossing of A: re-press A discarded, B latches.
    press(1'b1, 1'b0, 10);
    press(1'b0, 1'b1, 10);
    check("cross_b_latch", 32'(wait_b), 1);
    exp_q.push_back(1'b1);
    do_done();
    check("done_clr_a", 32'(wait_a), 0);
    check("done_keep_b", 32'(wait_b), 1);
    wait_grant("grant_b", 1'b1, cyc);
    check("min_green_b", 32'(cyc), 21);
    check("b_wait_a", 32'(wait_a), 0);
    do_ack();
    do_done();
    check("done_clr_b", 32'(wait_b), 0);

    // Both pending at expiry with rr=0: A first, then B.
    press(1'b1, 1'b1, 10);
    check("both_pend", 32'({wait_b, wait_a}), 3);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    wait_grant("both_first", 1'b0, cyc);
    do_ack();
    do_done();
    check("both_after", 32'({wait_b, wait_a}), 2);
    wait_grant("both_second", 1'b0, cyc);
    check("both_gap", 32'(cyc), 21);
    do_ack();

`ifdef CROSS_TIMEOUT_EN
    repeat (29) tick();
    check("to_early", 32'(fault), 0);
    tick();
    check("to_fault", 32'(fault), 1);
    check("to_clr_b", 32'(wait_b), 0);
`else
    repeat (40) tick();
    check("no_to_wait", 32'(wait_b), 1);
    check("no_to_fault", 32'(fault), 0);
    do_done();
    check("no_to_clr", 32'(wait_b), 0);
`endif

    // Reset mid-crossing of B with A pending.
    press(1'b0, 1'b1, 10);
    exp_q.push_back(1'b1);
    wait_grant("pre_rst", 1'b0, cyc);
    press(1'b1, 1'b0, 10);
    do_ack();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(req), 0);
    check("mid_rst_sel", 32'(sel), 0);
    check("mid_rst_wait", 32'({wait_a, wait_b}), 0);
    check("mid_rst_fault", 32'(fault), 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // After reset the min-green timer is reloaded: no grant before 20 cycles.
    press(1'b1, 1'b0, 10);
    exp_q.push_back(1'b0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req !== 1'b0) bad++;
    end
    check("post_rst_hold", 32'(bad), 0);
    wait_grant("post_rst", 1'b0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
